// File: rtl/gactx_tile_dispatcher.sv
// Job FIFO + round-robin dispatch/collect for a bank of GACTX arrays.
// Optional perf counters: define GACTX_DISPATCH_PERF_EN.
module gactx_tile_dispatcher #(
  parameter int NUM_ARRAY         = 4,
  parameter int LOG_NUM_ARRAY     = 2,
  parameter int JOB_FIFO_DEPTH    = 4,
  parameter int LOG_MAX_TILE_SIZE = 11,
  parameter int PE_WIDTH          = 25,
  parameter int JOB_ID_WIDTH      = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
`ifdef GACTX_DISPATCH_PERF_EN
  output logic [31:0]                                perf_jobs_done,
  output logic [31:0]                                perf_busy_cycles,
`endif
  input  logic                                       job_valid,
  output logic                                       job_ready,
  input  logic [JOB_ID_WIDTH-1:0]                    job_id,
  input  logic [LOG_MAX_TILE_SIZE-1:0]               job_ref_len,
  input  logic [LOG_MAX_TILE_SIZE-1:0]               job_query_len,
  input  logic [LOG_MAX_TILE_SIZE:0]                 job_max_tb_steps,
  input  logic [7:0]                                 job_align_fields,
  input  logic [NUM_ARRAY-1:0]                       arr_ready,
  input  logic [NUM_ARRAY-1:0]                       arr_done,
  output logic [NUM_ARRAY-1:0]                       arr_start,
  output logic [NUM_ARRAY-1:0]                       arr_clear_done,
  output logic [LOG_MAX_TILE_SIZE-1:0]               arr_ref_len,
  output logic [LOG_MAX_TILE_SIZE-1:0]               arr_query_len,
  output logic [LOG_MAX_TILE_SIZE:0]                 arr_max_tb_steps,
  output logic [7:0]                                 arr_align_fields,
  input  logic [NUM_ARRAY*PE_WIDTH-1:0]              arr_tile_score,
  input  logic [NUM_ARRAY*2*LOG_MAX_TILE_SIZE-1:0]   arr_num_tb_steps,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [JOB_ID_WIDTH-1:0]                    res_id,
  output logic [LOG_NUM_ARRAY-1:0]                   res_array,
  output logic [PE_WIDTH-1:0]                        res_tile_score,
  output logic [2*LOG_MAX_TILE_SIZE-1:0]             res_num_tb_steps
);
  localparam int L    = LOG_MAX_TILE_SIZE;
  localparam int FP_W = (JOB_FIFO_DEPTH > 1) ? $clog2(JOB_FIFO_DEPTH) : 1;
  localparam logic [FP_W:0] FULL_CNT = (FP_W+1)'(JOB_FIFO_DEPTH);

  typedef struct packed {
    logic [JOB_ID_WIDTH-1:0] id;
    logic [L-1:0]            ref_len;
    logic [L-1:0]            query_len;
    logic [L:0]              max_tb_steps;
    logic [7:0]              align_fields;
  } job_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE_PEND, S_CLEARING} slot_t;

  job_t                    mem [JOB_FIFO_DEPTH];
  job_t                    job_in, head;
  logic [FP_W-1:0]         wr_ptr, rd_ptr;
  logic [FP_W:0]           count;
  logic                    push, have_job, dispatch, capture;
  slot_t                   slot [NUM_ARRAY];
  logic [JOB_ID_WIDTH-1:0] id_table [NUM_ARRAY];
  logic [NUM_ARRAY-1:0]    disp_req, cap_req, disp_oh, cap_oh;
  logic [LOG_NUM_ARRAY-1:0] dispatch_ptr, result_ptr, disp_sel, cap_sel;
  logic                    disp_found, cap_found;

  function automatic logic [LOG_NUM_ARRAY:0] rr_pick(input logic [NUM_ARRAY-1:0] req,
                                                     input logic [LOG_NUM_ARRAY-1:0] ptr);
    logic [LOG_NUM_ARRAY:0] r;
    int idx;
    r = '0;
    // Scan from farthest to nearest so the request closest to ptr wins.
    for (int i = NUM_ARRAY-1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_ARRAY) idx -= NUM_ARRAY;
      if (req[idx]) r = {1'b1, idx[LOG_NUM_ARRAY-1:0]};
    end
    return r;
  endfunction

  function automatic logic [LOG_NUM_ARRAY-1:0] ptr_inc(input logic [LOG_NUM_ARRAY-1:0] p);
    return (int'(p) == NUM_ARRAY-1) ? '0 : p + 1'b1;
  endfunction

  assign job_ready = ~rst & (count != FULL_CNT);
  assign push      = job_valid & job_ready;
  assign job_in    = {job_id, job_ref_len, job_query_len, job_max_tb_steps, job_align_fields};
  // An empty FIFO forwards the incoming job so it can start the next cycle.
  assign head      = (count == '0) ? job_in : mem[rd_ptr];
  assign have_job  = (count != '0) | push;

  always_comb begin
    for (int k = 0; k < NUM_ARRAY; k++) begin
      disp_req[k] = (slot[k] == S_IDLE) & arr_ready[k];
      cap_req[k]  = (slot[k] == S_DONE_PEND);
    end
  end

  assign {disp_found, disp_sel} = rr_pick(disp_req, dispatch_ptr);
  assign {cap_found, cap_sel}   = rr_pick(cap_req, result_ptr);
  assign dispatch = have_job & disp_found;
  assign capture  = cap_found & (~res_valid | res_ready);
  assign disp_oh  = dispatch ? (NUM_ARRAY'(1) << disp_sel) : '0;
  assign cap_oh   = capture  ? (NUM_ARRAY'(1) << cap_sel)  : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ARRAY; k++) slot[k] <= S_IDLE;
    end else begin
      for (int k = 0; k < NUM_ARRAY; k++) begin
        case (slot[k])
          S_IDLE:      if (disp_oh[k])  slot[k] <= S_BUSY;
          S_BUSY:      if (arr_done[k]) slot[k] <= S_DONE_PEND;
          S_DONE_PEND: if (cap_oh[k])   slot[k] <= S_CLEARING;
          default:     if (!arr_done[k]) slot[k] <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dispatch_ptr     <= '0;
      result_ptr       <= '0;
      arr_start        <= '0;
      arr_clear_done   <= '0;
      arr_ref_len      <= '0;
      arr_query_len    <= '0;
      arr_max_tb_steps <= '0;
      arr_align_fields <= '0;
      res_valid        <= 1'b0;
      res_id           <= '0;
      res_array        <= '0;
      res_tile_score   <= '0;
      res_num_tb_steps <= '0;
      for (int k = 0; k < NUM_ARRAY; k++) id_table[k] <= '0;
    end else begin
      arr_start      <= disp_oh;
      arr_clear_done <= cap_oh;
      if (dispatch) begin
        dispatch_ptr       <= ptr_inc(disp_sel);
        arr_ref_len        <= head.ref_len;
        arr_query_len      <= head.query_len;
        arr_max_tb_steps   <= head.max_tb_steps;
        arr_align_fields   <= head.align_fields;
        id_table[disp_sel] <= head.id;
      end
      if (capture) begin
        result_ptr       <= ptr_inc(cap_sel);
        res_valid        <= 1'b1;
        res_id           <= id_table[cap_sel];
        res_array        <= cap_sel;
        res_tile_score   <= arr_tile_score[int'(cap_sel)*PE_WIDTH +: PE_WIDTH];
        res_num_tb_steps <= arr_num_tb_steps[int'(cap_sel)*2*L +: 2*L];
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef GACTX_DISPATCH_PERF_EN
  logic any_busy;
  always_comb begin
    any_busy = 1'b0;
    for (int k = 0; k < NUM_ARRAY; k++) any_busy |= (slot[k] != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs_done   <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (res_valid & res_ready & ~&perf_jobs_done) perf_jobs_done <= perf_jobs_done + 1'b1;
      if (any_busy & ~&perf_busy_cycles)            perf_busy_cycles <= perf_busy_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_gactx_tile_dispatcher.sv
// Directed bench for gactx_tile_dispatcher; a tiny array model drops done on clear_done.
module tb_gactx_tile_dispatcher;
  localparam int NA = 4, LNA = 2, FD = 4, L = 11, PW = 25, IW = 8;

  logic clk = 1'b0, rst = 1'b0;
  logic job_valid, job_ready;
  logic [IW-1:0] job_id;
  logic [L-1:0] job_ref_len, job_query_len;
  logic [L:0] job_max_tb_steps;
  logic [7:0] job_align_fields;
  logic [NA-1:0] arr_ready, arr_done, arr_start, arr_clear_done, set_done;
  logic [L-1:0] arr_ref_len, arr_query_len;
  logic [L:0] arr_max_tb_steps;
  logic [7:0] arr_align_fields;
  logic [NA*PW-1:0] arr_tile_score;
  logic [NA*2*L-1:0] arr_num_tb_steps;
  logic res_valid, res_ready;
  logic [IW-1:0] res_id;
  logic [LNA-1:0] res_array;
  logic [PW-1:0] res_tile_score;
  logic [2*L-1:0] res_num_tb_steps;
`ifdef GACTX_DISPATCH_PERF_EN
  logic [31:0] perf_jobs_done, perf_busy_cycles;
`endif

  int n_cmp = 0, n_err = 0;

  gactx_tile_dispatcher #(.NUM_ARRAY(NA), .LOG_NUM_ARRAY(LNA), .JOB_FIFO_DEPTH(FD),
    .LOG_MAX_TILE_SIZE(L), .PE_WIDTH(PW), .JOB_ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
`ifdef GACTX_DISPATCH_PERF_EN
    .perf_jobs_done(perf_jobs_done), .perf_busy_cycles(perf_busy_cycles),
`endif
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_ref_len(job_ref_len), .job_query_len(job_query_len),
    .job_max_tb_steps(job_max_tb_steps), .job_align_fields(job_align_fields),
    .arr_ready(arr_ready), .arr_done(arr_done), .arr_start(arr_start),
    .arr_clear_done(arr_clear_done), .arr_ref_len(arr_ref_len),
    .arr_query_len(arr_query_len), .arr_max_tb_steps(arr_max_tb_steps),
    .arr_align_fields(arr_align_fields), .arr_tile_score(arr_tile_score),
    .arr_num_tb_steps(arr_num_tb_steps), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_array(res_array), .res_tile_score(res_tile_score),
    .res_num_tb_steps(res_num_tb_steps));

  always #5 clk = ~clk;

  // Array model: done is raised by the bench, dropped after clear_done.
  always @(posedge clk or posedge rst) begin
    if (rst) arr_done <= '0;
    else     arr_done <= (arr_done | set_done) & ~arr_clear_done;
  end

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0; job_id = '0; job_ref_len = '0; job_query_len = '0;
    job_max_tb_steps = '0; job_align_fields = '0;
    arr_ready = '0; set_done = '0; res_ready = 1'b0;
    arr_tile_score = '0; arr_num_tb_steps = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (job_ready !== 1'b0 || arr_start !== '0 || arr_clear_done !== '0 || res_valid !== 1'b0 ||
        arr_ref_len !== '0 || res_id !== '0 || res_tile_score !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: job_ready=%b start=%b clr=%b res_valid=%b ref=%0d id=%0h want all 0",
               job_ready, arr_start, arr_clear_done, res_valid, arr_ref_len, res_id);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (job_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", job_ready); end
  endtask

  task automatic test_single();
    do_reset();
    arr_ready = 4'hF;
    arr_tile_score[0 +: PW] = 25'h1F4;
    arr_num_tb_steps[0 +: 2*L] = 22'd77;
    job_valid = 1'b1; job_id = 8'h5A; job_ref_len = 11'd100; job_query_len = 11'd90;
    job_max_tb_steps = 12'd300; job_align_fields = 8'h05;
    @(negedge clk);
    job_valid = 1'b0;
    n_cmp++;
    if (arr_start !== 4'b0001 || arr_ref_len !== 11'd100 || arr_query_len !== 11'd90 ||
        arr_max_tb_steps !== 12'd300 || arr_align_fields !== 8'h05) begin
      n_err++;
      $display("FAIL single_start: start=%b ref=%0d qry=%0d tb=%0d al=%0h want 0001/100/90/300/5",
               arr_start, arr_ref_len, arr_query_len, arr_max_tb_steps, arr_align_fields);
    end
    @(negedge clk);
    n_cmp++;
    if (arr_start !== 4'b0000) begin n_err++; $display("FAIL single_start_pulse: got %b want 0000", arr_start); end
    set_done = 4'b0001;
    @(negedge clk);
    set_done = '0;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_res_early: got %b want 0", res_valid); end
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 8'h5A || res_array !== 2'd0 || res_tile_score !== 25'h1F4 ||
        res_num_tb_steps !== 22'd77 || arr_clear_done !== 4'b0001) begin
      n_err++;
      $display("FAIL single_result: v=%b id=%0h arr=%0d score=%0h steps=%0d clr=%b want 1/5a/0/1f4/77/0001",
               res_valid, res_id, res_array, res_tile_score, res_num_tb_steps, arr_clear_done);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || arr_clear_done !== 4'b0000) begin
      n_err++; $display("FAIL single_drain: v=%b clr=%b want 0/0000", res_valid, arr_clear_done);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arr_ready = 4'hF; res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      job_valid = 1'b1; job_id = 8'(i + 1); job_ref_len = 11'(10 * (i + 1));
      job_query_len = 11'd5; job_max_tb_steps = 12'd9; job_align_fields = 8'h00;
      @(negedge clk);
      n_cmp++;
      if (i < 4) begin
        if (arr_start !== (4'b0001 << i) || arr_ref_len !== 11'(10 * (i + 1)) || job_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_start%0d: start=%b ref=%0d ready=%b want %b/%0d/1",
                   i, arr_start, arr_ref_len, job_ready, 4'b0001 << i, 10 * (i + 1));
        end
      end else if (arr_start !== 4'b0000 || job_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_wait%0d: start=%b ready=%b want 0000/1", i, arr_start, job_ready);
      end
    end
    job_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (arr_start !== 4'b0000) begin n_err++; $display("FAIL b2b_all_busy: got %b want 0000", arr_start); end
    for (int j = 0; j < 2; j++) begin
      bit seen;
      seen = 1'b0;
      set_done = 4'b0001 << j;
      @(negedge clk);
      set_done = '0;
      for (int c = 0; c < 20 && arr_start == 4'b0000; c++) begin
        @(negedge clk);
        if (res_valid) begin
          seen = 1'b1;
          n_cmp++;
          if (res_id !== 8'(j + 1) || res_array !== 2'(j)) begin
            n_err++; $display("FAIL b2b_res%0d: id=%0d arr=%0d want %0d/%0d", j, res_id, res_array, j + 1, j);
          end
        end
      end
      n_cmp++;
      if (!seen || arr_start !== (4'b0001 << j) || arr_ref_len !== 11'(50 + 10 * j)) begin
        n_err++;
        $display("FAIL b2b_refill%0d: seen=%b start=%b ref=%0d want 1/%b/%0d",
                 j, seen, arr_start, arr_ref_len, 4'b0001 << j, 50 + 10 * j);
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    arr_ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      job_valid = 1'b1; job_id = 8'(8'h11 + i); job_ref_len = 11'(20 + i);
      @(negedge clk);
      n_cmp++;
      if (job_ready !== (i < 3) || arr_start !== 4'b0000) begin
        n_err++; $display("FAIL full_fill%0d: ready=%b start=%b want %b/0000", i, job_ready, arr_start, i < 3);
      end
    end
    job_id = 8'h99; job_ref_len = 11'd999;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (job_ready !== 1'b0) begin n_err++; $display("FAIL full_hold: ready=%b want 0", job_ready); end
    end
    job_valid = 1'b0; arr_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (arr_start !== (4'b0001 << i) || arr_ref_len !== 11'(20 + i) || job_ready !== 1'b1) begin
        n_err++;
        $display("FAIL full_drain%0d: start=%b ref=%0d ready=%b want %b/%0d/1",
                 i, arr_start, arr_ref_len, job_ready, 4'b0001 << i, 20 + i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (arr_start !== 4'b0000) begin n_err++; $display("FAIL full_no_extra: start=%b want 0000", arr_start); end
  endtask

  task automatic test_simul_done();
    int c;
    do_reset();
    arr_ready = 4'hF;
    arr_tile_score[1*PW +: PW] = 25'h0AAA; arr_num_tb_steps[1*2*L +: 2*L] = 22'd11;
    arr_tile_score[2*PW +: PW] = 25'h0BBB; arr_num_tb_steps[2*2*L +: 2*L] = 22'd22;
    for (int i = 0; i < 3; i++) begin
      job_valid = 1'b1; job_id = 8'(8'hA0 + i); job_ref_len = 11'd7;
      @(negedge clk);
    end
    job_valid = 1'b0;
    set_done = 4'b0110;
    @(negedge clk);
    set_done = '0;
    c = 0;
    while (!res_valid && c < 10) begin @(negedge clk); c++; end
    n_cmp++;
    if (res_valid !== 1'b1 || res_array !== 2'd1 || res_id !== 8'hA1 || res_tile_score !== 25'h0AAA ||
        res_num_tb_steps !== 22'd11 || arr_clear_done !== 4'b0010) begin
      n_err++;
      $display("FAIL simul_first: v=%b arr=%0d id=%0h score=%0h steps=%0d clr=%b want 1/1/a1/aaa/11/0010",
               res_valid, res_array, res_id, res_tile_score, res_num_tb_steps, arr_clear_done);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || res_array !== 2'd1 || res_id !== 8'hA1 || res_tile_score !== 25'h0AAA ||
          arr_clear_done !== 4'b0000) begin
        n_err++;
        $display("FAIL simul_hold%0d: v=%b arr=%0d id=%0h score=%0h clr=%b want 1/1/a1/aaa/0000",
                 k, res_valid, res_array, res_id, res_tile_score, arr_clear_done);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_array !== 2'd2 || res_id !== 8'hA2 || res_tile_score !== 25'h0BBB ||
        res_num_tb_steps !== 22'd22 || arr_clear_done !== 4'b0100) begin
      n_err++;
      $display("FAIL simul_second: v=%b arr=%0d id=%0h score=%0h steps=%0d clr=%b want 1/2/a2/bbb/22/0100",
               res_valid, res_array, res_id, res_tile_score, res_num_tb_steps, arr_clear_done);
    end
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || arr_clear_done !== 4'b0000) begin
      n_err++; $display("FAIL simul_drain: v=%b clr=%b want 0/0000", res_valid, arr_clear_done);
    end
`ifdef GACTX_DISPATCH_PERF_EN
    n_cmp++;
    if (perf_jobs_done !== 32'd2) begin n_err++; $display("FAIL perf_jobs_done: got %0d want 2", perf_jobs_done); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    arr_ready = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      job_valid = 1'b1; job_id = 8'(i + 1); job_ref_len = 11'(10 * (i + 1));
      @(negedge clk);
    end
    job_valid = 1'b0;
    n_cmp++;
    if (job_ready !== 1'b1 || arr_ref_len !== 11'd20) begin
      n_err++; $display("FAIL mid_setup: ready=%b ref=%0d want 1/20", job_ready, arr_ref_len);
    end
    set_done = 4'b0001;
    @(negedge clk);
    set_done = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1 || res_id !== 8'd1) begin
      n_err++; $display("FAIL mid_inflight: v=%b id=%0d want 1/1", res_valid, res_id);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (job_ready !== 1'b0 || arr_start !== '0 || arr_clear_done !== '0 || res_valid !== 1'b0 ||
        res_id !== '0 || arr_ref_len !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: ready=%b start=%b clr=%b v=%b id=%0d ref=%0d want all 0",
               job_ready, arr_start, arr_clear_done, res_valid, res_id, arr_ref_len);
    end
    @(negedge clk);
    rst = 1'b0; arr_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (arr_start !== 4'b0000 || res_valid !== 1'b0 || job_ready !== 1'b1) begin
        n_err++;
        $display("FAIL mid_after%0d: start=%b v=%b ready=%b want 0000/0/1", k, arr_start, res_valid, job_ready);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_simul_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gactx_tile_dispatcher.md
Name: gactx_tile_dispatcher

Overview:
Schedules alignment tile jobs across NUM_ARRAY GACTX_Array instances that share one job stream and one result stream. It buffers job descriptors in a FIFO and issues each job to a free array with a one-cycle start pulse. It collects finished results round-robin, returns them over a valid/ready interface, and frees each array with clear_done. It sits between the host/DMA tile scheduler and the bank of alignment arrays.

Parameters:
NUM_ARRAY, 4, number of GACTX arrays managed (>=2)
LOG_NUM_ARRAY, 2, clog2(NUM_ARRAY)
JOB_FIFO_DEPTH, 4, job descriptor FIFO entries (power of 2)
LOG_MAX_TILE_SIZE, 11, tile length field width
PE_WIDTH, 25, score width
JOB_ID_WIDTH, 8, host job tag width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
job_valid  in  1  job descriptor valid
job_ready  out  1  FIFO can accept a job
job_id  in  JOB_ID_WIDTH  host tag
job_ref_len  in  LOG_MAX_TILE_SIZE  ref tile length
job_query_len  in  LOG_MAX_TILE_SIZE  query tile length
job_max_tb_steps  in  LOG_MAX_TILE_SIZE+1  traceback limit
job_align_fields  in  8  reverse/complement/start_last flags
arr_ready  in  NUM_ARRAY  per-array ready
arr_done  in  NUM_ARRAY  per-array done
arr_start  out  NUM_ARRAY  one-hot start pulse
arr_clear_done  out  NUM_ARRAY  one-hot clear_done pulse
arr_ref_len  out  LOG_MAX_TILE_SIZE  broadcast, valid with arr_start
arr_query_len  out  LOG_MAX_TILE_SIZE  broadcast
arr_max_tb_steps  out  LOG_MAX_TILE_SIZE+1  broadcast
arr_align_fields  out  8  broadcast
arr_tile_score  in  NUM_ARRAY*PE_WIDTH  flattened per-array tile_score
arr_num_tb_steps  in  NUM_ARRAY*2*LOG_MAX_TILE_SIZE  flattened per-array num_tb_steps
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_id  out  JOB_ID_WIDTH  tag of completed job
res_array  out  LOG_NUM_ARRAY  array index that ran it
res_tile_score  out  PE_WIDTH  captured score
res_num_tb_steps  out  2*LOG_MAX_TILE_SIZE  captured traceback step count

Behaviour:
- Reset (async, rst=1): FIFO empty; all array slots IDLE; both RR pointers 0. All outputs 0 (arr_start, arr_clear_done, res_valid, broadcast fields, res_* registers). job_ready=0 while rst is high.
- job_ready = ~full (combinational from registered count). Push when job_valid & job_ready. No push-through when full, even if a pop occurs in the same cycle.
- Per-array slot FSM: IDLE -> BUSY on dispatch; BUSY -> DONE_PEND when arr_done=1; DONE_PEND -> CLEARING on result capture; CLEARING -> IDLE when arr_done=0.
- Dispatch, at most one per cycle:
  - Eligible arrays: slot IDLE & arr_ready=1. Grant round-robin starting at dispatch_ptr; dispatch_ptr <= granted+1 mod NUM_ARRAY.
  - Registered outputs: arr_start[k]=1 for exactly one cycle, broadcast fields = FIFO head in that same cycle. FIFO pops, and id_table[k] <= head job_id.
  - Latency: job pushed at cycle t into an empty FIFO with a free array -> arr_start at t+1.
- Completion:
  - Capture is allowed when res_valid=0, or when res_valid & res_ready in this cycle (back-to-back results).
  - Pick a DONE_PEND array round-robin from result_ptr. Register res_id=id_table[k], res_array=k, res_tile_score and res_num_tb_steps from slice k. Set res_valid=1 and pulse arr_clear_done[k] for one cycle.
  - arr_done rise at t -> slot DONE_PEND at t+1 -> res_valid at t+2 if the output is free.
- res_valid holds with stable data until res_ready. res_valid & res_ready with nothing new to capture -> res_valid=0 next cycle.
- Dispatch and capture on different arrays in the same cycle are both performed.
- arr_done on a non-BUSY slot is ignored.
- arr_ready=0 on an IDLE slot: the slot is skipped (array not yet configured).
- FIFO empty: no arr_start. All slots busy: jobs wait in the FIFO.
- Reset mid-operation discards queued jobs and in-flight results. The arrays must be reset by the same rst.

Optional Feature:
GACTX_DISPATCH_PERF_EN:
- Defined: adds outputs perf_jobs_done (32b, +1 per result handshake) and perf_busy_cycles (32b, +1 each cycle any slot is not IDLE). Both saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist.

Test Plan:
- Single job, id=0x5A, ref_len=100, all arrays ready -> arr_start=4'b0001 at t+1 with arr_ref_len=100. On arr_done[0]=1 with score 0x1F4: res_valid, res_id=0x5A, res_array=0, res_tile_score=0x1F4, plus a one-cycle arr_clear_done[0].
- 6 jobs pushed back-to-back with all arrays free and idle -> starts on arrays 0,1,2,3 on consecutive cycles. job_ready drops only when 4 jobs are queued. Jobs 5-6 dispatch only after clears.
- arr_done[2] and arr_done[1] rise in the same cycle, result_ptr=0 -> array 1 result first, then array 2; each arr_clear_done pulses once.
- res_ready held 0 for 20 cycles with 2 finished arrays -> res_valid stays 1 with stable data. The second array stays DONE_PEND with no clear_done until the first handshake.
- rst asserted while 2 arrays are BUSY and 3 jobs are queued -> all outputs immediately 0. After release, job_ready=1 and no arr_start occurs without new pushes.
- (PERF) 3 results completed -> perf_jobs_done=3.
